logic_stream_unit: RTL
======================

Name: logic_stream_unit

Overview:
- Parametrised successor to the single-bit two-input gates: a WIDTH-bit bitwise logic unit covering AND/OR/XOR/NAND/NOR/XNOR.
- Registered output with valid/ready handshake on both sides.
- Adds an accumulate mode that folds a multi-beat packet of operand pairs into one result.
- Sits between operand sources and downstream logic in the game-style CPU datapath.

Parameters:
- WIDTH, 1, operand/result bit width (default reproduces the 1-bit gate).
- CNT_W, 8, width of the beat counter reported with each result.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  unit can accept a beat this cycle.
- in0  in  WIDTH  operand 0.
- in1  in  WIDTH  operand 1.
- op  in  3  0=AND 1=OR 2=XOR 3=NAND 4=NOR 5=XNOR; 6,7 decode as OR.
- mode  in  1  0=pair, 1=accumulate; sampled on first beat of a packet only.
- in_last  in  1  final beat of an accumulate packet; ignored in pair mode.
- out_valid  out  1  result held on out.
- out_ready  in  1  consumer takes result.
- out  out  WIDTH  result.
- out_count  out  CNT_W  beats folded into result; saturates at 2^CNT_W-1.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, acc=0, cnt=0, out=0, out_valid=0, out_count=0. Reset mid-packet discards the packet; no output is produced for it.
- Accept: accept = in_valid && in_ready.
- in_ready = !out_valid || out_ready, held in every state. Combinational from out_ready only; no path from in_valid.
- Op decode: base op (AND/OR/XOR) plus invert flag. Ops 3-5 are the inverses of ops 0-2.
- IDLE, accept with mode=0 (pair): out <= invert ? ~(in0 base in1) : (in0 base in1); out_count <= 1; out_valid <= 1. Latency is 1 cycle. State stays IDLE.
- IDLE, accept with mode=1 and in_last=0: latch op; acc <= in0 base in1; cnt <= 1; go to ACCUM. No output.
- IDLE, accept with mode=1 and in_last=1: single-beat packet, identical result to pair mode.
- ACCUM, accept: acc_n = acc base in0 base in1, using the latched op; cnt <= sat(cnt+1). Mode and op inputs are ignored.
  - in_last=0: acc <= acc_n.
  - in_last=1: out <= invert ? ~acc_n : acc_n; out_count <= sat(cnt+1); out_valid <= 1; acc <= 0; go to IDLE.
- Output hold: out and out_count are stable while out_valid && !out_ready.
- Output complete: out_valid && out_ready with no new result in the same cycle -> out_valid <= 0. out keeps its last value.
- Simultaneous drain and load: out_valid && out_ready and a result-producing accept in the same cycle -> the new result replaces the old one and out_valid stays 1. No bubble.
- Mid-packet beats do not wait on the output slot being empty at the protocol level, but in_ready still follows the global rule, which keeps the logic simple.
- Width: all operations are bitwise; no carries. Counter saturates and never wraps.

Decomposition:
- Package logic_unit_pkg: op code constants/enum (OP_AND..OP_XNOR), MODE_PAIR/MODE_ACC, state enum {IDLE, ACCUM}, and a base_op/invert decode function.
- Sub-module logic_op_core: purely combinational WIDTH-bit a base b with optional invert. It is instantiated for the pair path and the fold path.

Test Plan:
- WIDTH=1, pair, op=1, out_ready=1; (0,0),(1,0),(0,1),(1,1) on consecutive cycles -> out=0,1,1,1, each one cycle after accept; out_count=1.
- WIDTH=8, accumulate, op=XOR; beats (0x0F,0xF0),(0xFF,0x00),(0x3C,0x00,last) -> single result out=0x3C, out_count=3. No out_valid before the last beat.
- WIDTH=8, accumulate, op=NAND; (0xFF,0xFF),(0xF0,0xFF,last) -> out=0x0F, out_count=2.
- Backpressure: result pending with out_ready=0 -> in_ready=0 and out stable for 5 cycles. Then out_ready=1 with a pair beat AND 0xA5&0x0F -> same-cycle accept, out=0x05 next cycle, out_valid continuously 1.
- rst=1 after 2 accumulate beats -> all outputs 0. Next packet (0x01,0x02,last) OR -> out=0x03, out_count=1 (old acc not leaked).
- CNT_W=2, accumulate OR, 5 beats -> out_count=3 (saturated); out equals the OR of all 10 operands.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_pkg
// Shared definitions for the logic stream unit: operation codes, packet mode
// encodings, the control state enum and the op decoder that splits every
// operation into a base function (AND/OR/XOR) plus an output-invert flag.
// -----------------------------------------------------------------------------
package logic_unit_pkg;

  // Operation codes carried on the op input. Codes 6 and 7 decode as OR.
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  // Packet modes, sampled on the first beat of a packet.
  localparam logic MODE_PAIR = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  typedef enum logic [1:0] {
    BASE_AND = 2'd0,
    BASE_OR  = 2'd1,
    BASE_XOR = 2'd2
  } base_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  typedef struct packed {
    base_e base;
    logic  invert;
  } op_dec_t;

  // Inverting ops are the complements of ops 0-2, so the fold runs on the
  // base function and the invert is applied only to the final result.
  function automatic op_dec_t decode_op(input logic [2:0] op);
    op_dec_t d;
    d.base   = BASE_OR;
    d.invert = 1'b0;
    case (op)
      OP_AND:  d.base = BASE_AND;
      OP_OR:   d.base = BASE_OR;
      OP_XOR:  d.base = BASE_XOR;
      OP_NAND: begin d.base = BASE_AND; d.invert = 1'b1; end
      OP_NOR:  begin d.base = BASE_OR;  d.invert = 1'b1; end
      OP_XNOR: begin d.base = BASE_XOR; d.invert = 1'b1; end
      default: d.base = BASE_OR;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/logic_stream_unit_if.sv
// -----------------------------------------------------------------------------
// logic_stream_unit_if
// Operand/result stream bundle for logic_stream_unit.
//   in_valid/in_ready : operand beat handshake (source -> unit)
//   in0, in1          : WIDTH-bit operands
//   op, mode, in_last : operation, pair/accumulate mode, last beat of packet
//   out_valid/out_ready : result handshake (unit -> consumer)
//   out, out_count    : result and number of beats folded into it
// Modports: master = operand source / result consumer side, slave = unit.
// -----------------------------------------------------------------------------
interface logic_stream_unit_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [2:0]       op;
  logic             mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in0, in1, op, mode, in_last, out_ready,
    input  in_ready, out_valid, out, out_count
  );

  modport slave (
    input  in_valid, in0, in1, op, mode, in_last, out_ready,
    output in_ready, out_valid, out, out_count
  );

endinterface

// File: rtl/logic_op_core.sv
// -----------------------------------------------------------------------------
// logic_op_core
// Purely combinational WIDTH-bit bitwise unit: raw_o = a_i <base> b_i and
// y_o = raw_o, optionally inverted. The raw value feeds further folding, the
// inverted one is the user-visible result.
//   a_i, b_i  : operands
//   base_i    : AND / OR / XOR
//   invert_i  : complement the result on y_o
//   raw_o     : un-inverted result
//   y_o       : final result
// -----------------------------------------------------------------------------
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  base_e            base_i,
  input  logic             invert_i,
  output logic [WIDTH-1:0] raw_o,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    case (base_i)
      BASE_AND: raw_o = a_i & b_i;
      BASE_XOR: raw_o = a_i ^ b_i;
      default:  raw_o = a_i | b_i;
    endcase
  end

  assign y_o = invert_i ? ~raw_o : raw_o;

endmodule

// File: rtl/logic_stream_unit.sv
// -----------------------------------------------------------------------------
// logic_stream_unit
// WIDTH-bit bitwise logic unit (AND/OR/XOR/NAND/NOR/XNOR) with a registered,
// valid/ready result. Pair mode produces one result per beat; accumulate mode
// folds every operand of a multi-beat packet into a single result and reports
// the (saturating) beat count alongside it.
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : operand/result stream (slave side of logic_stream_unit_if)
// -----------------------------------------------------------------------------
module logic_stream_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  logic_stream_unit_if.slave  bus
);

  state_e           state_q, state_d;
  op_dec_t          op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_valid_q, out_valid_d;

  op_dec_t          op_in;
  base_e            beat_base;
  logic             in_ready;
  logic             accept;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] beat_raw, beat_res;
  logic [WIDTH-1:0] fold_raw, fold_res;

  // The slot can take a beat whenever it is empty or being drained this
  // cycle; deliberately independent of in_valid to avoid a comb loop upstream.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  assign op_in = decode_op(bus.op);

  // Inside a packet the op latched on the first beat governs every beat.
  assign beat_base = (state_q == ACCUM) ? op_q.base : op_in.base;

  // Beat counter saturates at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // Pair path: in0 <base> in1. raw seeds/extends the fold, res is the
  // complete single-beat result.
  logic_op_core #(.WIDTH(WIDTH)) u_beat (
    .a_i      (bus.in0),
    .b_i      (bus.in1),
    .base_i   (beat_base),
    .invert_i (op_in.invert),
    .raw_o    (beat_raw),
    .y_o      (beat_res)
  );

  // Fold path: acc <base> (in0 <base> in1); the base ops are associative so
  // this equals acc <base> in0 <base> in1.
  logic_op_core #(.WIDTH(WIDTH)) u_fold (
    .a_i      (acc_q),
    .b_i      (beat_raw),
    .base_i   (op_q.base),
    .invert_i (op_q.invert),
    .raw_o    (fold_raw),
    .y_o      (fold_res)
  );

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;

    // Drain first; a result produced below in the same cycle overrides it.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.mode == MODE_PAIR || bus.in_last) begin
            out_d       = beat_res;
            out_cnt_d   = CNT_W'(1);
            out_valid_d = 1'b1;
          end else begin
            op_d    = op_in;
            acc_d   = beat_raw;
            cnt_d   = CNT_W'(1);
            state_d = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (accept) begin
          if (!bus.in_last) begin
            acc_d = fold_raw;
            cnt_d = cnt_inc;
          end else begin
            out_d       = fold_res;
            out_cnt_d   = cnt_inc;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '{base: BASE_AND, invert: 1'b0};
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.out_count = out_cnt_q;

endmodule
